// File: rtl/cpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_seq_ctrl
// Purpose  : Multi-cycle IF/ID/EX/MEM/WB sequencer for the RV32I core.
//            Sequences one instruction at a time and adds:
//              - watchdog timeouts on instruction/data memory waits
//              - halt at the instruction boundary (after WB)
//              - illegal-instruction fault state with cause reporting
//              - retired-instruction counter
// Config   : `define SEQ_TIMEOUT_EN to compile in the wait watchdog.
//            Without it, IF and MEM wait forever and fault_cause is 0 or 3.
// Ports    : clk, rst_n (async, active-low)
//            imem_rdy, dmem_rdy               memory ready inputs
//            dec_mem_read/write, dec_reg_write,
//            dec_illegal                       decoder outputs (ID..WB stable)
//            halt_req, clear_fault             control requests
//            state[2:0]                        IF=0 ID=1 EX=2 MEM=3 WB=4
//                                              HALT=5 FAULT=6
//            fetch_en, dmem_ren, dmem_wen,
//            rf_wen, pc_we, halted, fault      strobes / status
//            fault_cause[1:0]                  0 none,1 imem,2 dmem,3 illegal
//            retire_cnt[RETIRE_W-1:0]          retired instruction count
// Revision : 1.0 - initial release
// ============================================================================
module cpu_seq_ctrl #(
  parameter int TIMEOUT_W    = 8,
  parameter int IMEM_TIMEOUT = 255,
  parameter int DMEM_TIMEOUT = 255,
  parameter int RETIRE_W     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                imem_rdy,
  input  logic                dmem_rdy,
  input  logic                dec_mem_read,
  input  logic                dec_mem_write,
  input  logic                dec_reg_write,
  input  logic                dec_illegal,
  input  logic                halt_req,
  input  logic                clear_fault,
  output logic [2:0]          state,
  output logic                fetch_en,
  output logic                dmem_ren,
  output logic                dmem_wen,
  output logic                rf_wen,
  output logic                pc_we,
  output logic                halted,
  output logic                fault,
  output logic [1:0]          fault_cause,
  output logic [RETIRE_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  localparam logic [1:0] c_cause_none    = 2'd0;
  localparam logic [1:0] c_cause_illegal = 2'd3;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_fault_cause;
  logic [1:0]          w_fault_cause_nxt;
  logic                r_dmem_ren;
  logic                r_dmem_wen;
  logic                w_dmem_ren_nxt;
  logic                w_dmem_wen_nxt;
  logic [RETIRE_W-1:0] r_retire_cnt;
  logic                w_mem_op;

`ifdef SEQ_TIMEOUT_EN
  // The counter holds the number of not-ready cycles already seen, so the
  // N-th consecutive miss is the cycle in which it equals N-1.
  localparam logic [TIMEOUT_W-1:0] c_imem_lim = TIMEOUT_W'(IMEM_TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] c_dmem_lim = TIMEOUT_W'(DMEM_TIMEOUT - 1);
  localparam logic [1:0]           c_cause_imem = 2'd1;
  localparam logic [1:0]           c_cause_dmem = 2'd2;

  logic [TIMEOUT_W-1:0] r_wd;
  logic [TIMEOUT_W-1:0] w_wd_nxt;
`endif

  assign w_mem_op = dec_mem_read | dec_mem_write;

  // --------------------------------------------------------------------------
  // Next-state and registered-output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_fault_cause_nxt = r_fault_cause;
    // Memory request pulses are launched from EX so they appear registered
    // during the first MEM cycle only. A read takes priority over a write.
    w_dmem_ren_nxt    = (r_state == S_EX) & dec_mem_read;
    w_dmem_wen_nxt    = (r_state == S_EX) & dec_mem_write & ~dec_mem_read;
`ifdef SEQ_TIMEOUT_EN
    w_wd_nxt          = r_wd;
`endif
    case (r_state)
      S_IF: begin
        // Ready is tested first so it wins over a simultaneous timeout.
        if (imem_rdy) begin
          w_state_nxt = S_ID;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (r_wd == c_imem_lim) begin
          w_state_nxt       = S_FAULT;
          w_fault_cause_nxt = c_cause_imem;
        end else begin
          w_wd_nxt = r_wd + 1'b1;
        end
`endif
      end
      S_ID: begin
        if (dec_illegal) begin
          w_state_nxt       = S_FAULT;
          w_fault_cause_nxt = c_cause_illegal;
        end else begin
          w_state_nxt = S_EX;
        end
      end
      S_EX: begin
        w_state_nxt = S_MEM;
`ifdef SEQ_TIMEOUT_EN
        w_wd_nxt    = '0;
`endif
      end
      S_MEM: begin
        if (!w_mem_op || dmem_rdy) begin
          w_state_nxt = S_WB;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (r_wd == c_dmem_lim) begin
          w_state_nxt       = S_FAULT;
          w_fault_cause_nxt = c_cause_dmem;
        end else begin
          w_wd_nxt = r_wd + 1'b1;
        end
`endif
      end
      S_WB: begin
        w_state_nxt = halt_req ? S_HALT : S_IF;
`ifdef SEQ_TIMEOUT_EN
        w_wd_nxt    = '0;
`endif
      end
      S_HALT: begin
        if (!halt_req) begin
          w_state_nxt = S_IF;
`ifdef SEQ_TIMEOUT_EN
          w_wd_nxt    = '0;
`endif
        end
      end
      S_FAULT: begin
        if (clear_fault) begin
          w_state_nxt       = S_IF;
          w_fault_cause_nxt = c_cause_none;
`ifdef SEQ_TIMEOUT_EN
          w_wd_nxt          = '0;
`endif
        end
      end
      default: begin
        w_state_nxt       = S_IF;
        w_fault_cause_nxt = c_cause_none;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IF;
      r_fault_cause <= c_cause_none;
      r_dmem_ren    <= 1'b0;
      r_dmem_wen    <= 1'b0;
      r_retire_cnt  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_fault_cause <= w_fault_cause_nxt;
      r_dmem_ren    <= w_dmem_ren_nxt;
      r_dmem_wen    <= w_dmem_wen_nxt;
      if (r_state == S_WB) begin
        r_retire_cnt <= r_retire_cnt + 1'b1;
      end
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd <= '0;
    end else begin
      r_wd <= w_wd_nxt;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Outputs: strobes decode directly from the state register so an
  // asynchronous reset removes them in the same instant.
  // --------------------------------------------------------------------------
  assign state       = r_state;
  assign fetch_en    = (r_state == S_IF);
  assign dmem_ren    = r_dmem_ren;
  assign dmem_wen    = r_dmem_wen;
  assign rf_wen      = (r_state == S_WB) & dec_reg_write;
  assign pc_we       = (r_state == S_WB);
  assign halted      = (r_state == S_HALT);
  assign fault       = (r_state == S_FAULT);
  assign fault_cause = r_fault_cause;
  assign retire_cnt  = r_retire_cnt;

endmodule
`default_nettype wire

// File: doc/cpu_seq_ctrl.md
# cpu_seq_ctrl

Parametrised multi-cycle sequencer for the RV32I core: the IF/ID/EX/MEM/WB controller split out of the CPU top into its own block. It adds watchdog timeouts on instruction and data memory waits, store-ready handshaking, a halt-at-boundary request, an illegal-instruction fault state and a retired-instruction counter. It sits between the `Control` decoder outputs, the IMem/DMem interfaces, `PC_Control` and `RegFile`.

## Interface
- `TIMEOUT_W`, 8: width of the wait watchdog counter.
- `IMEM_TIMEOUT`, 255: consecutive IF cycles without `imem_rdy` before a fault; range 1..2^TIMEOUT_W-1.
- `DMEM_TIMEOUT`, 255: consecutive MEM wait cycles without `dmem_rdy` before a fault; same range.
- `RETIRE_W`, 32: width of the retire counter.

- `clk` in 1: single clock; every register updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_rdy` in 1: instruction word is valid.
- `dmem_rdy` in 1: data access is complete.
- `dec_mem_read`, `dec_mem_write`, `dec_reg_write`, `dec_illegal` in 1 each: decoder outputs, stable from ID through WB.
- `halt_req` in 1: stop at the next instruction boundary.
- `clear_fault` in 1: leave the FAULT state.
- `state` out 3: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, FAULT=6.
- `fetch_en` out 1: high while `state`==IF.
- `dmem_ren`, `dmem_wen` out 1: one-cycle request pulses.
- `rf_wen` out 1: register-file write strobe.
- `pc_we` out 1: PC update strobe.
- `halted` out 1: high while in HALT.
- `fault` out 1: high while in FAULT.
- `fault_cause` out 2: 0 = none, 1 = IMEM timeout, 2 = DMEM timeout, 3 = illegal instruction.
- `retire_cnt` out RETIRE_W: count of retired instructions.

## Operation
- IF: stay in IF until `imem_rdy`=1, then go to ID.
- ID: if `dec_illegal`=1, go to FAULT with cause 3; otherwise go to EX.
- EX: always go to MEM after one cycle.
- MEM:
  - Load or store: wait for `dmem_rdy`, then go to WB. `dmem_rdy` seen in the first MEM cycle counts.
  - Neither: go to WB after one cycle.
- WB: the instruction retires here. Next state is HALT if `halt_req`=1, otherwise IF.
- HALT: stay while `halt_req`=1. Go to IF in the cycle after `halt_req` is seen low.
- FAULT: stay until `clear_fault`=1, then go to IF and clear `fault_cause` to 0.
- A faulting instruction never reaches WB: no `rf_wen`, no `pc_we`, no retire.
- `dmem_ren`/`dmem_wen`:
  - Registered; high only in the first MEM cycle.
  - `dmem_ren` = `dec_mem_read`; `dmem_wen` = `dec_mem_write` & ~`dec_mem_read`.
- `rf_wen` = `dec_reg_write` in the WB cycle only. `pc_we` = 1 in the WB cycle only.
- `retire_cnt`: +1 per WB cycle, wraps from 2^RETIRE_W-1 to 0.
- Watchdog counter:
  - Cleared on entry to IF and on entry to MEM.
  - Increments each wait cycle.
  - A ready seen in the same cycle the limit is reached wins over the timeout.

## Timing
- Reset values: `state`=IF, `fetch_en`=1. `dmem_ren`, `dmem_wen`, `rf_wen`, `pc_we`, `halted`, `fault` all 0. `fault_cause`=0, `retire_cnt`=0, watchdog=0.
- Reset is asynchronous and valid mid-instruction: outputs take their reset values immediately. No write strobe may be emitted after `rst_n` falls.
- Minimum latency: 5 cycles per instruction (IF, ID, EX, MEM, WB), with `imem_rdy` and, for memory ops, `dmem_rdy` in their first wait cycle. Each extra wait cycle adds 1.
- Timeout: with limit N, N consecutive not-ready cycles put `state` in FAULT on the following cycle.
- `halt_req` and `clear_fault` are sampled only in the states named above. They are ignored elsewhere.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - Watchdog compiled in.
  - Causes 1 and 2 are reachable.
- `SEQ_TIMEOUT_EN` undefined:
  - No watchdog counter.
  - IF and MEM wait indefinitely.
  - `fault_cause` takes only the values 0 and 3.
  - All other behaviour is identical.

## Test plan
- ALU op, `imem_rdy` held 1, `dec_reg_write`=1 -> `state` sequence 0,1,2,3,4,0. `rf_wen` and `pc_we` high in cycle 5 only. `retire_cnt` 0→1.
- Load, `dmem_rdy` arrives 3 cycles after entering MEM -> `dmem_ren` high for 1 cycle. `state` = MEM for 4 cycles, then WB. Total 8 cycles.
- `SEQ_TIMEOUT_EN`, `IMEM_TIMEOUT`=4, `imem_rdy`=0 -> FAULT after 4 IF cycles, `fault_cause`=1. `clear_fault` pulse -> IF, cause 0. `retire_cnt` unchanged.
- `dec_illegal`=1 in ID -> FAULT, cause 3, no `rf_wen` or `pc_we`. Then `halt_req`=1 during a WB -> HALT, `halted`=1. Drop `halt_req` -> IF on the next cycle.
- `RETIRE_W`=4, run 17 instructions -> `retire_cnt` goes 15→0→1. Assert `rst_n`=0 in MEM of a store -> `dmem_wen`=0 and `state`=0 immediately, all outputs at reset values.
